// File: rtl/tpu_pkg.sv
// Shared constants, element types and the address decoder for the tpu_v1 matrix-multiply core.
package tpu_pkg;

  localparam int BITS_AB     = 8;
  localparam int BITS_C      = 16;
  localparam int DIM         = 8;
  localparam int ADDRW       = 16;
  localparam int DATAW       = 64;
  localparam int DIM_LOG2    = $clog2(DIM);
  localparam int HALF        = DIM / 2;
  localparam int BUSY_CYCLES = 3 * DIM;
  localparam int CNTW        = $clog2(BUSY_CYCLES);

  localparam logic [ADDRW-1:0] A_BASE       = 16'h0100;
  localparam logic [ADDRW-1:0] B_BASE       = 16'h0200;
  localparam logic [ADDRW-1:0] C_BASE       = 16'h0300;
  localparam logic [ADDRW-1:0] START        = 16'h0400;
  localparam logic [ADDRW-1:0] C_ROW_STRIDE = 16'h0010;

  typedef logic signed [BITS_AB-1:0] ab_elem_t;
  typedef logic signed [BITS_C-1:0]  c_elem_t;

  typedef enum logic [2:0] {REG_A, REG_B, REG_C, REG_START, REG_NONE} region_e;

  // The whole 0x200 page pushes into the B FIFO; A and C accept any offset within their row windows.
  function automatic region_e decodeAddr(input logic [ADDRW-1:0] a);
    if (a >= A_BASE && a < A_BASE + ADDRW'(DIM * 8))
      return REG_A;
    else if (a >= B_BASE && a <= 16'h02FF)
      return REG_B;
    else if (a >= C_BASE && a < C_BASE + ADDRW'(DIM) * C_ROW_STRIDE)
      return REG_C;
    else if (a == START)
      return REG_START;
    else
      return REG_NONE;
  endfunction

endpackage

// File: rtl/tpu_systolic_array.sv
// DIM x DIM output-stationary MAC grid; A enters from the left skewed by row, B from the top skewed by column.
module tpu_systolic_array
  import tpu_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                macEn_i,
  input  ab_elem_t            aFeed_i [DIM],
  input  ab_elem_t            bFeed_i [DIM],
  input  logic                cWrEn_i,
  input  logic [DIM_LOG2-1:0] cWrRow_i,
  input  logic                cWrHalf_i,
  input  logic [DATAW-1:0]    cWrData_i,
  output c_elem_t             cOut_o [DIM][DIM]
);

  ab_elem_t aSkewed [DIM];
  ab_elem_t bSkewed [DIM];
  ab_elem_t aPass_q [DIM][DIM-1];
  ab_elem_t bPass_q [DIM-1][DIM];
  c_elem_t  acc_q   [DIM][DIM];

  // Row/column n is delayed n cycles so A[i][k] and B[k][j] meet in PE(i,j) at the same edge.
  for (genvar n = 0; n < DIM; n++) begin : g_skew
    if (n == 0) begin : g_direct
      assign aSkewed[n] = aFeed_i[n];
      assign bSkewed[n] = bFeed_i[n];
    end else begin : g_delay
      ab_elem_t aSh_q [n];
      ab_elem_t bSh_q [n];
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          aSh_q <= '{default: '0};
          bSh_q <= '{default: '0};
        end else begin
          aSh_q[0] <= aFeed_i[n];
          bSh_q[0] <= bFeed_i[n];
          for (int s = 1; s < n; s++) begin
            aSh_q[s] <= aSh_q[s-1];
            bSh_q[s] <= bSh_q[s-1];
          end
        end
      end
      assign aSkewed[n] = aSh_q[n-1];
      assign bSkewed[n] = bSh_q[n-1];
    end
  end

  for (genvar i = 0; i < DIM; i++) begin : g_row
    for (genvar j = 0; j < DIM; j++) begin : g_col
      localparam logic [DIM_LOG2-1:0] ROW = DIM_LOG2'(i);
      localparam logic                HI  = (j >= HALF);
      ab_elem_t aIn;
      ab_elem_t bIn;
      c_elem_t  prod;

      if (j == 0) begin : g_aedge
        assign aIn = aSkewed[i];
      end else begin : g_ain
        assign aIn = aPass_q[i][j-1];
      end
      if (i == 0) begin : g_bedge
        assign bIn = bSkewed[j];
      end else begin : g_bin
        assign bIn = bPass_q[i-1][j];
      end

      assign prod = c_elem_t'(aIn) * c_elem_t'(bIn);

      if (j < DIM - 1) begin : g_apass
        always_ff @(posedge clk or posedge rst) begin
          if (rst) aPass_q[i][j] <= '0;
          else     aPass_q[i][j] <= aIn;
        end
      end
      if (i < DIM - 1) begin : g_bpass
        always_ff @(posedge clk or posedge rst) begin
          if (rst) bPass_q[i][j] <= '0;
          else     bPass_q[i][j] <= bIn;
        end
      end

      // Host preload and MAC never coincide: the top blocks C writes while busy.
      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          acc_q[i][j] <= '0;
        else if (cWrEn_i && cWrRow_i == ROW && cWrHalf_i == HI)
          acc_q[i][j] <= cWrData_i[(j % HALF)*BITS_C +: BITS_C];
        else if (macEn_i)
          acc_q[i][j] <= acc_q[i][j] + prod;
      end

      assign cOut_o[i][j] = acc_q[i][j];
    end
  end

endmodule

// File: rtl/tpu_v1.sv
// Bus-facing top of the 8x8 matrix-multiply core: decode, A/B buffers, feed counter and busy control.
module tpu_v1
  import tpu_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             r_w,
  input  logic [ADDRW-1:0] addr,
  input  logic [DATAW-1:0] dataIn,
  output logic [DATAW-1:0] dataOut,
  output logic             rdValid
);

  region_e             region;
  logic                busy_q, busy_d;
  logic [CNTW-1:0]     cnt_q, cnt_d;
  logic [DATAW-1:0]    aMem_q  [DIM];
  logic [DATAW-1:0]    bFifo_q [DIM];
  logic [DIM_LOG2-1:0] aRow, cRow, feedIdx;
  logic                cHalf, feedOn;
  logic                wrA, wrB, wrC, wrStart;
  ab_elem_t            aFeed [DIM];
  ab_elem_t            bFeed [DIM];
  c_elem_t             cArr  [DIM][DIM];

  assign region  = decodeAddr(addr);
  assign aRow    = addr[3 +: DIM_LOG2];
  assign cRow    = addr[4 +: DIM_LOG2];
  assign cHalf   = addr[3];
  assign wrA     = r_w && !busy_q && region == REG_A;
  assign wrB     = r_w && !busy_q && region == REG_B;
  assign wrC     = r_w && !busy_q && region == REG_C;
  assign wrStart = r_w && !busy_q && region == REG_START;

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    if (busy_q) begin
      if (cnt_q == CNTW'(BUSY_CYCLES - 1)) begin
        busy_d = 1'b0;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (wrStart) begin
      busy_d = 1'b1;
      cnt_d  = '0;
    end
  end

  // The FIFO shifts toward index 0, so after DIM pushes index k holds the k-th push (B row k).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      aMem_q  <= '{default: '0};
      bFifo_q <= '{default: '0};
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      if (wrA)
        aMem_q[aRow] <= dataIn;
      if (wrB) begin
        for (int k = 0; k < DIM - 1; k++)
          bFifo_q[k] <= bFifo_q[k+1];
        bFifo_q[DIM-1] <= dataIn;
      end
    end
  end

  assign feedIdx = cnt_q[DIM_LOG2-1:0];
  assign feedOn  = busy_q && cnt_q < CNTW'(DIM);

  // Cycle k of a run presents column k of A and row k of B; zeros afterwards flush the pipelines.
  always_comb begin
    for (int n = 0; n < DIM; n++) begin
      aFeed[n] = '0;
      bFeed[n] = '0;
      if (feedOn) begin
        aFeed[n] = ab_elem_t'(aMem_q[n][BITS_AB*feedIdx +: BITS_AB]);
        bFeed[n] = ab_elem_t'(bFifo_q[feedIdx][BITS_AB*n +: BITS_AB]);
      end
    end
  end

  tpu_systolic_array u_array (
    .clk       (clk),
    .rst       (rst),
    .macEn_i   (busy_q),
    .aFeed_i   (aFeed),
    .bFeed_i   (bFeed),
    .cWrEn_i   (wrC),
    .cWrRow_i  (cRow),
    .cWrHalf_i (cHalf),
    .cWrData_i (dataIn),
    .cOut_o    (cArr)
  );

  always_comb begin
    dataOut = '0;
    if (region == REG_C && !busy_q)
      for (int k = 0; k < HALF; k++)
        dataOut[k*BITS_C +: BITS_C] = cHalf ? cArr[cRow][k+HALF] : cArr[cRow][k];
  end

  assign rdValid = !r_w && region == REG_C && !busy_q;

endmodule

// File: tb/tb_tpu_v1.sv
// Scoreboard bench for tpu_v1: a software model predicts every C word, reads are popped and compared.
module tb_tpu_v1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        r_w = 1'b0;
  logic [15:0] addr = '0;
  logic [63:0] dataIn = '0;
  logic [63:0] dataOut;
  logic        rdValid;

  int          vectors = 0;
  int          miscompares = 0;
  int          mA [8][8];
  int          mB [8][8];
  logic [15:0] mC [8][8];
  logic [15:0] expAddr [$];
  logic [63:0] expData [$];

  tpu_v1 dut (
    .clk     (clk),
    .rst     (rst),
    .r_w     (r_w),
    .addr    (addr),
    .dataIn  (dataIn),
    .dataOut (dataOut),
    .rdValid (rdValid)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic writeWord(input logic [15:0] a, input logic [63:0] d);
    @(negedge clk);
    r_w = 1'b1; addr = a; dataIn = d;
    @(negedge clk);
    r_w = 1'b0; dataIn = '0;
  endtask

  function automatic logic [63:0] packC(input int r, input int h);
    logic [63:0] w;
    for (int k = 0; k < 4; k++) w[k*16 +: 16] = mC[r][h*4+k];
    return w;
  endfunction

  function automatic logic [63:0] packRow(input int m [8][8], input int r);
    logic [63:0] w;
    for (int k = 0; k < 8; k++) w[k*8 +: 8] = 8'(m[r][k]);
    return w;
  endfunction

  task automatic pushAllC();
    for (int r = 0; r < 8; r++)
      for (int h = 0; h < 2; h++) begin
        expAddr.push_back(16'(16'h300 + r*16 + h*8));
        expData.push_back(packC(r, h));
      end
  endtask

  task automatic drainCheck(input string tag);
    logic [15:0] a;
    logic [63:0] e;
    while (expAddr.size() > 0) begin
      a = expAddr.pop_front();
      e = expData.pop_front();
      @(negedge clk);
      r_w = 1'b0; addr = a;
      #1;
      checkOutput(tag, dataOut, e);
      checkOutput({tag, "_rdValid"}, 64'(rdValid), 64'd1);
    end
  endtask

  task automatic pulseReset();
    @(negedge clk);
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) mC[i][j] = '0;
  endtask

  task automatic applyStimulus();
    writeWord(16'h2F8, 64'hDEAD_BEEF_DEAD_BEEF);
    for (int r = 0; r < 8; r++) writeWord(16'(16'h100 + r*8), packRow(mA, r));
    for (int k = 0; k < 8; k++) writeWord(16'(16'h200 + k*16 + 3), packRow(mB, k));
    for (int r = 0; r < 8; r++)
      for (int h = 0; h < 2; h++) writeWord(16'(16'h300 + r*16 + h*8), packC(r, h));
  endtask

  task automatic waitDone(input int n0);
    int n;
    n = n0;
    r_w = 1'b0; addr = 16'h300;
    #1;
    while (rdValid !== 1'b1 && n < 33) begin
      @(negedge clk);
      #1;
      n++;
    end
    checkOutput("latency", 64'(n), 64'd24);
  endtask

  task automatic runCompute(input string tag, input bit junk);
    int s;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) begin
        s = 0;
        for (int k = 0; k < 8; k++) s += mA[i][k] * mB[k][j];
        mC[i][j] = mC[i][j] + s[15:0];
      end
    pushAllC();
    writeWord(16'h400, 64'd1);
    if (junk) begin
      writeWord(16'h300, '1);
      addr = 16'h300;
      #1;
      checkOutput("busy_dataOut", dataOut, 64'd0);
      checkOutput("busy_rdValid", 64'(rdValid), 64'd0);
      waitDone(2);
    end else begin
      waitDone(0);
    end
    drainCheck(tag);
  endtask

  task automatic fillAB(input int aVal, input int bVal, input bit rnd);
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) begin
        mA[i][j] = rnd ? int'($urandom_range(0, 255)) - 128 : aVal;
        mB[i][j] = rnd ? int'($urandom_range(0, 255)) - 128 : bVal;
      end
  endtask

  task automatic fillC(input logic [15:0] v);
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) mC[i][j] = v;
  endtask

  initial begin
    fillC('0);
    #12 rst = 1'b0;

    pushAllC();
    drainCheck("reset_c");

    writeWord(16'h318, 64'h0123_4567_89AB_CDEF);
    for (int k = 0; k < 4; k++) mC[1][4+k] = 16'(64'h0123_4567_89AB_CDEF >> (k*16));
    expAddr.push_back(16'h318); expData.push_back(packC(1, 1));
    expAddr.push_back(16'h310); expData.push_back(packC(1, 0));
    drainCheck("c_write");
    pulseReset();
    expAddr.push_back(16'h318); expData.push_back(packC(1, 1));
    drainCheck("c_after_rst");

    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) begin
        mA[i][j] = (i == j) ? 1 : 0;
        mB[i][j] = i + 1 + j;
      end
    fillC('0);
    applyStimulus();
    @(negedge clk); addr = 16'h100; #1;
    checkOutput("a_read_zero", dataOut, 64'd0);
    @(negedge clk); addr = 16'h200; #1;
    checkOutput("b_read_zero", dataOut, 64'd0);
    checkOutput("b_rdValid", 64'(rdValid), 64'd0);
    runCompute("identity", 1'b0);

    for (int t = 0; t < 5; t++) begin
      fillAB(0, 0, 1'b1);
      fillC('0);
      applyStimulus();
      runCompute("random", 1'b0);
    end

    fillAB(1, 1, 1'b0);
    fillC(16'd5);
    applyStimulus();
    runCompute("accum1", 1'b0);
    runCompute("accum2", 1'b0);

    fillAB(-128, -128, 1'b0);
    fillC('0);
    applyStimulus();
    runCompute("edge_neg", 1'b0);

    fillAB(127, -128, 1'b0);
    fillC('0);
    applyStimulus();
    runCompute("edge_mix", 1'b0);

    fillAB(0, 0, 1'b1);
    fillC(16'h1234);
    applyStimulus();
    runCompute("busy_ignore", 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
